// File: rtl/block_a_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blockA_pkg
// Purpose  : Shared types, register offsets and FSM state encoding for
//            block_a and its register sub-module.
// Contents : aSt / aASt / seeSt payload types, APB address/data types,
//            register offset constants, sequencer state enum.
// Revision : 1.0 - initial release
// ============================================================================
package blockA_pkg;

    typedef logic [3:0]  aSt;
    typedef logic        aASt;
    typedef logic [4:0]  seeSt;
    typedef logic [31:0] apbAddrSt;
    typedef logic [31:0] apbDataSt;

    localparam logic [11:0] c_OFF_CTRL   = 12'h000;
    localparam logic [11:0] c_OFF_ADATA  = 12'h004;
    localparam logic [11:0] c_OFF_CDATA  = 12'h008;
    localparam logic [11:0] c_OFF_STATUS = 12'h00C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_A_REQ  = 2'd1,
        ST_C_SEND = 2'd2,
        ST_NOTIFY = 2'd3
    } fsmSt;

endpackage
`default_nettype wire

// File: rtl/block_a_regs.sv
`default_nettype none
// ============================================================================
// Module   : block_a_regs
// Purpose  : APB slave for block_a: address decode, ADATA/CDATA registers,
//            STATUS read-back, START acceptance and pslverr generation.
// Ports    : clk, rst_n (sync, active-high)
//            paddr/psel/penable/pwrite/pwdata  - APB request
//            pready/prdata/pslverr             - APB response
//            busy/done/rdataBit/count          - status from the sequencer
//            startAccept                       - START accepted this cycle
//            aData/cData                       - programmed payloads
// Revision : 1.0 - initial release
// ============================================================================
module block_a_regs
    import blockA_pkg::*;
#(
    parameter apbAddrSt REG_BASE = 32'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  apbAddrSt   paddr,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  apbDataSt   pwdata,
    output logic       pready,
    output apbDataSt   prdata,
    output logic       pslverr,
    input  logic       busy,
    input  logic       done,
    input  aASt        rdataBit,
    input  logic [7:0] count,
    output logic       startAccept,
    output aSt         aData,
    output seeSt       cData
);

    logic        w_access;
    logic        w_hit;
    logic [11:0] w_off;
    logic        w_err;
    logic        w_start;
    logic        w_wrA;
    logic        w_wrC;
    apbDataSt    w_rdData;
    aSt          r_aData;
    seeSt        r_cData;
    logic        w_unused;

    assign w_access = psel & penable;
    // Only the 4 KB window starting at REG_BASE belongs to this block.
    assign w_hit    = (paddr[31:12] == REG_BASE[31:12]);
    assign w_off    = paddr[11:0];
    assign w_unused = &{1'b0, pwdata[31:5]};

    always_comb begin
        w_err    = 1'b0;
        w_start  = 1'b0;
        w_wrA    = 1'b0;
        w_wrC    = 1'b0;
        w_rdData = '0;
        if (w_access) begin
            if (!w_hit) begin
                w_err = 1'b1;
            end else begin
                case (w_off)
                    c_OFF_CTRL: begin
                        // A START request while busy is refused, not queued.
                        if (pwrite && pwdata[0]) begin
                            if (busy) w_err   = 1'b1;
                            else      w_start = 1'b1;
                        end
                    end
                    c_OFF_ADATA: begin
                        if (pwrite) w_wrA    = 1'b1;
                        else        w_rdData = {28'd0, r_aData};
                    end
                    c_OFF_CDATA: begin
                        if (pwrite) w_wrC    = 1'b1;
                        else        w_rdData = {27'd0, r_cData};
                    end
                    c_OFF_STATUS: begin
                        if (pwrite) w_err    = 1'b1;
                        else        w_rdData = {16'd0, count, 5'd0, rdataBit, done, busy};
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_aData <= '0;
            r_cData <= '0;
        end else begin
            if (w_wrA) r_aData <= pwdata[3:0];
            if (w_wrC) r_cData <= pwdata[4:0];
        end
    end

    assign pready      = 1'b1;
    assign prdata      = w_rdData;
    assign pslverr     = w_err;
    assign startAccept = w_start;
    assign aData       = r_aData;
    assign cData       = r_cData;

endmodule
`default_nettype wire

// File: rtl/block_a.sv
`default_nettype none
// ============================================================================
// Module   : block_a
// Purpose  : APB-programmed sequencer. On START it performs one req/ack on
//            aStuffIf, one parallel beat on cStuffIf and dupIf, then one
//            notify/ack on startDone.
// Ports    : clk, rst_n (sync, active-high)
//            aStuffIf*  - req/data out, ack/rdata in
//            cStuffIf*  - vld/data out, rdy in
//            dupIf*     - vld/data out, rdy in (same payload as cStuffIf)
//            startDone* - notify out, ack in
//            apbReg*    - APB slave
// Revision : 1.0 - initial release
// ============================================================================
module block_a
    import blockA_pkg::*;
#(
    parameter apbAddrSt REG_BASE = 32'h0
) (
    input  logic     clk,
    input  logic     rst_n,
    output logic     aStuffIfReq,
    output aSt       aStuffIfData,
    input  logic     aStuffIfAck,
    input  aASt      aStuffIfRdata,
    output logic     cStuffIfVld,
    output seeSt     cStuffIfData,
    input  logic     cStuffIfRdy,
    output logic     dupIfVld,
    output seeSt     dupIfData,
    input  logic     dupIfRdy,
    output logic     startDoneNotify,
    input  logic     startDoneAck,
    input  apbAddrSt apbRegPaddr,
    input  logic     apbRegPsel,
    input  logic     apbRegPenable,
    input  logic     apbRegPwrite,
    input  apbDataSt apbRegPwdata,
    output logic     apbRegPready,
    output apbDataSt apbRegPrdata,
    output logic     apbRegPslverr
);

    fsmSt       r_state;
    fsmSt       w_nextState;
    aSt         r_aShadow;
    seeSt       r_cShadow;
    logic       r_cAcc;
    logic       r_dAcc;
    logic       r_done;
    aASt        r_rdata;
    logic [7:0] r_count;
    logic       w_busy;
    logic       w_startAccept;
    aSt         w_aData;
    seeSt       w_cData;
    logic       w_aReq;
    logic       w_cVld;
    logic       w_dVld;
    logic       w_notify;
    logic       w_aCapture;
    logic       w_complete;

    assign w_busy = (r_state != ST_IDLE);

    block_a_regs #(
        .REG_BASE (REG_BASE)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .paddr       (apbRegPaddr),
        .psel        (apbRegPsel),
        .penable     (apbRegPenable),
        .pwrite      (apbRegPwrite),
        .pwdata      (apbRegPwdata),
        .pready      (apbRegPready),
        .prdata      (apbRegPrdata),
        .pslverr     (apbRegPslverr),
        .busy        (w_busy),
        .done        (r_done),
        .rdataBit    (r_rdata),
        .count       (r_count),
        .startAccept (w_startAccept),
        .aData       (w_aData),
        .cData       (w_cData)
    );

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= ST_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_aReq      = 1'b0;
        w_cVld      = 1'b0;
        w_dVld      = 1'b0;
        w_notify    = 1'b0;
        w_aCapture  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_startAccept) w_nextState = ST_A_REQ;
            end
            ST_A_REQ: begin
                w_aReq = 1'b1;
                if (aStuffIfAck) begin
                    w_aCapture  = 1'b1;
                    w_nextState = ST_C_SEND;
                end
            end
            ST_C_SEND: begin
                // Each sink retires its own beat; leave once both have,
                // including the case where both accept in the same cycle.
                w_cVld = ~r_cAcc;
                w_dVld = ~r_dAcc;
                if ((r_cAcc | (w_cVld & cStuffIfRdy)) &&
                    (r_dAcc | (w_dVld & dupIfRdy)))
                    w_nextState = ST_NOTIFY;
            end
            ST_NOTIFY: begin
                w_notify = 1'b1;
                if (startDoneAck) begin
                    w_complete  = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_aShadow <= '0;
            r_cShadow <= '0;
            r_cAcc    <= 1'b0;
            r_dAcc    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            // Payloads are frozen at START so later APB writes cannot
            // disturb data already in flight.
            if (w_startAccept) begin
                r_aShadow <= w_aData;
                r_cShadow <= w_cData;
                r_done    <= 1'b0;
            end
            if (w_aCapture) r_rdata <= aStuffIfRdata;
            if (r_state == ST_C_SEND) begin
                if (w_cVld && cStuffIfRdy) r_cAcc <= 1'b1;
                if (w_dVld && dupIfRdy)    r_dAcc <= 1'b1;
            end else begin
                r_cAcc <= 1'b0;
                r_dAcc <= 1'b0;
            end
            if (w_complete) begin
                r_done  <= 1'b1;
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign aStuffIfReq     = w_aReq;
    assign aStuffIfData    = w_aReq ? r_aShadow : '0;
    assign cStuffIfVld     = w_cVld;
    assign cStuffIfData    = w_cVld ? r_cShadow : '0;
    assign dupIfVld        = w_dVld;
    assign dupIfData       = w_dVld ? r_cShadow : '0;
    assign startDoneNotify = w_notify;

endmodule
`default_nettype wire

// File: tb/tb_block_a.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_a
// Purpose  : Directed self-checking bench for block_a.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_a;
    import blockA_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     aStuffIfReq;
    aSt       aStuffIfData;
    logic     aStuffIfAck;
    aASt      aStuffIfRdata;
    logic     cStuffIfVld;
    seeSt     cStuffIfData;
    logic     cStuffIfRdy;
    logic     dupIfVld;
    seeSt     dupIfData;
    logic     dupIfRdy;
    logic     startDoneNotify;
    logic     startDoneAck;
    apbAddrSt apbRegPaddr;
    logic     apbRegPsel;
    logic     apbRegPenable;
    logic     apbRegPwrite;
    apbDataSt apbRegPwdata;
    logic     apbRegPready;
    apbDataSt apbRegPrdata;
    logic     apbRegPslverr;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    block_a #(
        .REG_BASE (32'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .aStuffIfReq     (aStuffIfReq),
        .aStuffIfData    (aStuffIfData),
        .aStuffIfAck     (aStuffIfAck),
        .aStuffIfRdata   (aStuffIfRdata),
        .cStuffIfVld     (cStuffIfVld),
        .cStuffIfData    (cStuffIfData),
        .cStuffIfRdy     (cStuffIfRdy),
        .dupIfVld        (dupIfVld),
        .dupIfData       (dupIfData),
        .dupIfRdy        (dupIfRdy),
        .startDoneNotify (startDoneNotify),
        .startDoneAck    (startDoneAck),
        .apbRegPaddr     (apbRegPaddr),
        .apbRegPsel      (apbRegPsel),
        .apbRegPenable   (apbRegPenable),
        .apbRegPwrite    (apbRegPwrite),
        .apbRegPwdata    (apbRegPwdata),
        .apbRegPready    (apbRegPready),
        .apbRegPrdata    (apbRegPrdata),
        .apbRegPslverr   (apbRegPslverr)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data, output logic err);
        nextCycle();
        apbRegPaddr   = addr;
        apbRegPwdata  = data;
        apbRegPwrite  = 1'b1;
        apbRegPsel    = 1'b1;
        apbRegPenable = 1'b0;
        nextCycle();
        apbRegPenable = 1'b1;
        @(negedge clk);
        err = apbRegPslverr;
        nextCycle();
        apbRegPsel    = 1'b0;
        apbRegPenable = 1'b0;
        apbRegPwrite  = 1'b0;
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data, output logic err);
        nextCycle();
        apbRegPaddr   = addr;
        apbRegPwrite  = 1'b0;
        apbRegPsel    = 1'b1;
        apbRegPenable = 1'b0;
        nextCycle();
        apbRegPenable = 1'b1;
        @(negedge clk);
        data = apbRegPrdata;
        err  = apbRegPslverr;
        nextCycle();
        apbRegPsel    = 1'b0;
        apbRegPenable = 1'b0;
    endtask

    // One complete sequence with immediate acks and both sinks ready.
    task automatic runSeq();
        logic e;
        apbWrite(32'h0, 32'h1, e);
        aStuffIfAck = 1'b1;
        nextCycle();
        aStuffIfAck = 1'b0;
        nextCycle();
        startDoneAck = 1'b1;
        nextCycle();
        startDoneAck = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d;

        rst_n         = 1'b1;
        aStuffIfAck   = 1'b0;
        aStuffIfRdata = 1'b0;
        cStuffIfRdy   = 1'b0;
        dupIfRdy      = 1'b0;
        startDoneAck  = 1'b0;
        apbRegPaddr   = '0;
        apbRegPsel    = 1'b0;
        apbRegPenable = 1'b0;
        apbRegPwrite  = 1'b0;
        apbRegPwdata  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_req",     {31'd0, aStuffIfReq},     32'd0);
        checkVal("rst_cvld",    {31'd0, cStuffIfVld},     32'd0);
        checkVal("rst_dvld",    {31'd0, dupIfVld},        32'd0);
        checkVal("rst_notify",  {31'd0, startDoneNotify}, 32'd0);
        checkVal("rst_pready",  {31'd0, apbRegPready},    32'd1);
        checkVal("rst_pslverr", {31'd0, apbRegPslverr},   32'd0);
        checkVal("rst_prdata",  apbRegPrdata,             32'd0);
        rst_n = 1'b0;
        apbRead(32'hC, d, e);
        checkVal("rst_status", d, 32'h0000_0000);

        // Basic sequence
        apbWrite(32'h4, 32'hA, e);
        apbWrite(32'h8, 32'h15, e);
        cStuffIfRdy = 1'b1;
        dupIfRdy    = 1'b1;
        apbWrite(32'h0, 32'h1, e);
        checkVal("t2_start_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        checkVal("t2_req",   {31'd0, aStuffIfReq},  32'd1);
        checkVal("t2_adata", {28'd0, aStuffIfData}, 32'hA);
        apbRead(32'hC, d, e);
        checkVal("t2_busy", d, 32'h0000_0001);
        aStuffIfAck   = 1'b1;
        aStuffIfRdata = 1'b1;
        nextCycle();
        aStuffIfAck   = 1'b0;
        aStuffIfRdata = 1'b0;
        @(negedge clk);
        checkVal("t2_req_drop", {31'd0, aStuffIfReq},  32'd0);
        checkVal("t2_cvld",     {31'd0, cStuffIfVld},  32'd1);
        checkVal("t2_cdata",    {27'd0, cStuffIfData}, 32'h15);
        checkVal("t2_dupdata",  {27'd0, dupIfData},    32'h15);
        nextCycle();
        @(negedge clk);
        checkVal("t2_notify",   {31'd0, startDoneNotify}, 32'd1);
        checkVal("t2_cvld_low", {31'd0, cStuffIfVld},     32'd0);
        nextCycle();
        nextCycle();
        startDoneAck = 1'b1;
        nextCycle();
        startDoneAck = 1'b0;
        @(negedge clk);
        checkVal("t2_notify_drop", {31'd0, startDoneNotify}, 32'd0);
        apbRead(32'hC, d, e);
        checkVal("t2_status", d, 32'h0000_0106);

        // Independent sink acceptance
        cStuffIfRdy = 1'b0;
        dupIfRdy    = 1'b0;
        apbWrite(32'h0, 32'h1, e);
        aStuffIfAck = 1'b1;
        nextCycle();
        aStuffIfAck = 1'b0;
        @(negedge clk);
        checkVal("t3_cvld", {31'd0, cStuffIfVld}, 32'd1);
        checkVal("t3_dvld", {31'd0, dupIfVld},    32'd1);
        cStuffIfRdy = 1'b1;
        nextCycle();
        cStuffIfRdy = 1'b0;
        @(negedge clk);
        checkVal("t3_cvld_drop", {31'd0, cStuffIfVld},     32'd0);
        checkVal("t3_dvld_hold", {31'd0, dupIfVld},        32'd1);
        checkVal("t3_no_notify", {31'd0, startDoneNotify}, 32'd0);
        repeat (3) nextCycle();
        @(negedge clk);
        checkVal("t3_dvld_wait",  {31'd0, dupIfVld},        32'd1);
        checkVal("t3_no_notify2", {31'd0, startDoneNotify}, 32'd0);
        dupIfRdy = 1'b1;
        nextCycle();
        dupIfRdy = 1'b0;
        @(negedge clk);
        checkVal("t3_dvld_drop", {31'd0, dupIfVld},        32'd0);
        checkVal("t3_notify",    {31'd0, startDoneNotify}, 32'd1);
        startDoneAck = 1'b1;
        nextCycle();
        startDoneAck = 1'b0;

        // START while busy, payload shadowing
        cStuffIfRdy = 1'b1;
        dupIfRdy    = 1'b1;
        apbWrite(32'h0, 32'h1, e);
        apbWrite(32'h8, 32'h03, e);
        checkVal("t4_cdata_wr_err", {31'd0, e}, 32'd0);
        apbWrite(32'h0, 32'h1, e);
        checkVal("t4_busy_start_err", {31'd0, e}, 32'd1);
        @(negedge clk);
        checkVal("t4_req_held", {31'd0, aStuffIfReq},  32'd1);
        checkVal("t4_adata",    {28'd0, aStuffIfData}, 32'hA);
        apbRead(32'h8, d, e);
        checkVal("t4_cdata_reg", d, 32'h03);
        aStuffIfAck = 1'b1;
        nextCycle();
        aStuffIfAck = 1'b0;
        @(negedge clk);
        checkVal("t4_cdata_shadow", {27'd0, cStuffIfData}, 32'h15);
        checkVal("t4_dup_shadow",   {27'd0, dupIfData},    32'h15);
        nextCycle();
        startDoneAck = 1'b1;
        nextCycle();
        startDoneAck = 1'b0;

        // Unmapped / read-only errors and COUNT wrap
        apbRead(32'h10, d, e);
        checkVal("t5_unmapped_err",    {31'd0, e}, 32'd1);
        checkVal("t5_unmapped_prdata", d,          32'd0);
        apbWrite(32'hC, 32'hFFFF_FFFF, e);
        checkVal("t5_status_wr_err", {31'd0, e}, 32'd1);
        apbRead(32'hC, d, e);
        checkVal("t5_status_nochg", d, 32'h0000_0302);
        for (int i = 0; i < 252; i++) runSeq();
        apbRead(32'hC, d, e);
        checkVal("t5_count_255", d, 32'h0000_FF02);
        runSeq();
        apbRead(32'hC, d, e);
        checkVal("t5_count_wrap", d, 32'h0000_0002);

        // Reset during NOTIFY
        apbWrite(32'h0, 32'h1, e);
        aStuffIfAck = 1'b1;
        nextCycle();
        aStuffIfAck = 1'b0;
        nextCycle();
        @(negedge clk);
        checkVal("t6_notify", {31'd0, startDoneNotify}, 32'd1);
        rst_n = 1'b1;
        nextCycle();
        @(negedge clk);
        checkVal("t6_notify_drop", {31'd0, startDoneNotify}, 32'd0);
        rst_n = 1'b0;
        // Stray acks in IDLE must not complete anything.
        startDoneAck = 1'b1;
        aStuffIfAck  = 1'b1;
        nextCycle();
        startDoneAck = 1'b0;
        aStuffIfAck  = 1'b0;
        apbRead(32'hC, d, e);
        checkVal("t6_status", d, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
